// File: rtl/gelu_result_packer_pkg.sv
// Shared SFU types for the function-unit result packers.
// Default geometry matches the GELU writeback stream.
package gelu_result_packer_pkg;

  localparam int SFU_DATA_WIDTH = 32;
  localparam int SFU_PACK_LANES = 4;

  typedef struct packed {
    logic [SFU_DATA_WIDTH*SFU_PACK_LANES-1:0] data;
    logic [SFU_PACK_LANES-1:0]                strb;
    logic                                     last;
  } sfu_word_t;

endpackage

// File: rtl/gelu_result_packer_if.sv
// Packed-word writeback stream between a packer and the SFU
// writeback stage.
interface gelu_result_packer_if
  import gelu_result_packer_pkg::*;
#(
  parameter int DATA_WIDTH = SFU_DATA_WIDTH,
  parameter int LANES      = SFU_PACK_LANES
);

  logic [DATA_WIDTH*LANES-1:0] out_data;
  logic [LANES-1:0]            out_strb;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output out_data,
    output out_strb,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_strb,
    input  out_last,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/gelu_result_packer_sfu_out_slot.sv
// Single-entry valid/ready output register shared by the
// SFU packers; a load is only issued while slot_free is high.
module sfu_out_slot
  import gelu_result_packer_pkg::*;
#(
  parameter type T = sfu_word_t
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  T     din,
  output logic slot_free,
  output logic valid,
  input  logic ready,
  output T     dout
);

  logic valid_q, valid_d;
  T     word_q,  word_d;

  assign slot_free = ~valid_q | ready;
  assign valid     = valid_q;
  assign dout      = word_q;

  always_comb begin
    valid_d = valid_q & ~ready;
    word_d  = word_q;
    if (load) begin
      valid_d = 1'b1;
      word_d  = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: rtl/gelu_result_packer.sv
// Packs LANES consecutive GELU results into one writeback word,
// stalling the pipeline instead of dropping results.
module gelu_result_packer
  import gelu_result_packer_pkg::*;
#(
  parameter int DATA_WIDTH = SFU_DATA_WIDTH,
  parameter int LANES      = SFU_PACK_LANES,
  parameter int CNT_W      = $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_vld,
  output logic                  res_en,
  input  logic                  flush,
  gelu_result_packer_if.master  pk
);

  localparam int WW = DATA_WIDTH * LANES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  typedef struct packed {
    logic [WW-1:0]    data;
    logic [LANES-1:0] strb;
    logic             last;
  } word_t;

  logic [CNT_W-1:0] lane_idx_q, lane_idx_d;
  logic             pend_flush_q, pend_flush_d;
  logic [WW-1:0]    acc_q, acc_d, acc_w;
  logic             slot_free, load, accept;
  word_t            word_in, word_out;

  assign res_en = ~((lane_idx_q == LAST) & ~slot_free)
                & ~pend_flush_q;
  assign accept = res_vld & res_en;

  always_comb begin
    acc_w        = acc_q;
    acc_d        = acc_q;
    lane_idx_d   = lane_idx_q;
    pend_flush_d = pend_flush_q;
    load         = 1'b0;
    word_in      = '0;
    if (accept)
      acc_w[int'(lane_idx_q)*DATA_WIDTH +: DATA_WIDTH] = res_data;
    unique case (1'b1)
      pend_flush_q: begin
        if (slot_free) begin
          load         = 1'b1;
          word_in.data = acc_q;
          word_in.last = 1'b1;
          for (int i = 0; i < LANES; i++)
            word_in.strb[i] = (i < int'(lane_idx_q));
          acc_d        = '0;
          lane_idx_d   = '0;
          pend_flush_d = 1'b0;
        end
      end
      accept && (lane_idx_q == LAST): begin
        load         = 1'b1;
        word_in.data = acc_w;
        word_in.strb = '1;
        word_in.last = flush;
        acc_d        = '0;
        lane_idx_d   = '0;
      end
      accept && (lane_idx_q != LAST): begin
        acc_d        = acc_w;
        lane_idx_d   = lane_idx_q + 1'b1;
        pend_flush_d = flush;
      end
      // A flush with nothing buffered has no word to close.
      flush && !accept && !pend_flush_q && (lane_idx_q != '0):
        pend_flush_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx_q   <= '0;
      pend_flush_q <= 1'b0;
      acc_q        <= '0;
    end else begin
      lane_idx_q   <= lane_idx_d;
      pend_flush_q <= pend_flush_d;
      acc_q        <= acc_d;
    end
  end

  sfu_out_slot #(.T(word_t)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (word_in),
    .slot_free (slot_free),
    .valid     (pk.out_valid),
    .ready     (pk.out_ready),
    .dout      (word_out)
  );

  assign pk.out_data = word_out.data;
  assign pk.out_strb = word_out.strb;
  assign pk.out_last = word_out.last;

endmodule

// File: tb/tb_gelu_result_packer.sv
// Bench for gelu_result_packer: directed table, corner sequences
// and a randomized run against a word-level reference model.
module tb_gelu_result_packer;

  localparam int DW = 32;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] res_data = '0;
  logic          res_vld = 1'b0;
  logic          res_en;
  logic          flush = 1'b0;

  gelu_result_packer_if #(.DATA_WIDTH(DW), .LANES(L)) pk ();

  gelu_result_packer #(.DATA_WIDTH(DW), .LANES(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .res_data (res_data),
    .res_vld  (res_vld),
    .res_en   (res_en),
    .flush    (flush),
    .pk       (pk)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic         s_en, s_v, s_l;
  logic [127:0] s_d;
  logic [3:0]   s_s;

  logic [31:0]  cur[$];
  bit           m_pend, m_v, m_l;
  logic [127:0] m_d;
  logic [3:0]   m_s;

  typedef struct {
    bit           v;
    logic [31:0]  d;
    bit           f;
    bit           r;
    bit           en;
    bit           ov;
    logic [127:0] od;
    logic [3:0]   os;
    bit           ol;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    m_pend = 0; m_v = 0; m_l = 0;
    m_d = '0; m_s = '0;
  endtask

  task automatic emit(input bit last);
    m_v = 1;
    m_d = '0;
    foreach (cur[i]) m_d[i*32 +: 32] = cur[i];
    m_s = 4'((1 << cur.size()) - 1);
    m_l = last;
    cur.delete();
  endtask

  // One clock: drive, sample, compare with model, advance model.
  task automatic cyc(input bit v, input logic [31:0] d, input bit f,
                     input bit r, input bit rs = 0);
    bit free, en, acc;
    @(negedge clk);
    rst = rs; res_vld = v; res_data = d; flush = f;
    pk.out_ready = r;
    #1;
    s_en = res_en; s_v = pk.out_valid; s_d = pk.out_data;
    s_s = pk.out_strb; s_l = pk.out_last;
    if (rs) begin
      model_reset();
    end else begin
      free = !m_v || r;
      en   = !(cur.size() == L-1 && !free) && !m_pend;
      acc  = v && en;
      chk("model_res_en", s_en, en);
      chk("model_valid", s_v, m_v);
      if (m_v) begin
        chk("model_data", s_d, m_d);
        chk("model_strb", s_s, m_s);
        chk("model_last", s_l, m_l);
      end
      if (m_v && r) m_v = 0;
      if (m_pend) begin
        if (free) begin emit(1); m_pend = 0; end
      end else if (acc) begin
        cur.push_back(d);
        if (cur.size() == L) emit(f);
        else if (f) m_pend = 1;
      end else if (f && cur.size() != 0) begin
        m_pend = 1;
      end
    end
  endtask

  initial begin
    bit hv, hf, hr, acc_prev, stall_prev;
    logic [31:0] hd;
    logic [127:0] p_d;
    logic [4:0] p_sl;
    int n_acc, n_out;
    pk.out_ready = 1'b1;

    tbl[0]  = '{1, 32'h3F800000, 0, 1, 1, 0, '0, 4'h0, 0};
    tbl[1]  = '{1, 32'h40000000, 0, 1, 1, 0, '0, 4'h0, 0};
    tbl[2]  = '{1, 32'h40400000, 0, 1, 1, 0, '0, 4'h0, 0};
    tbl[3]  = '{1, 32'h40800000, 0, 1, 1, 0, '0, 4'h0, 0};
    tbl[4]  = '{0, 32'h0, 0, 1, 1, 1,
      128'h40800000_40400000_40000000_3F800000, 4'hF, 0};
    tbl[5]  = '{1, 32'h11111111, 0, 1, 1, 0, '0, 4'h0, 0};
    tbl[6]  = '{1, 32'h22222222, 0, 1, 1, 0, '0, 4'h0, 0};
    tbl[7]  = '{0, 32'h0, 1, 1, 1, 0, '0, 4'h0, 0};
    tbl[8]  = '{0, 32'h0, 0, 1, 0, 0, '0, 4'h0, 0};
    tbl[9]  = '{0, 32'h0, 0, 1, 1, 1,
      128'h00000000_00000000_22222222_11111111, 4'h3, 1};
    tbl[10] = '{1, 32'h33333333, 0, 1, 1, 0, '0, 4'h0, 0};
    tbl[11] = '{1, 32'h44444444, 0, 1, 1, 0, '0, 4'h0, 0};
    tbl[12] = '{1, 32'h55555555, 0, 1, 1, 0, '0, 4'h0, 0};
    tbl[13] = '{1, 32'h66666666, 0, 1, 1, 0, '0, 4'h0, 0};
    tbl[14] = '{0, 32'h0, 0, 1, 1, 1,
      128'h66666666_55555555_44444444_33333333, 4'hF, 0};

    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    chk("rst_valid", s_v, 0);
    chk("rst_data", s_d, 0);
    chk("rst_strb", s_s, 0);
    chk("rst_last", s_l, 0);
    chk("rst_res_en", s_en, 1);

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      chk($sformatf("tbl%0d_en", i), s_en, tbl[i].en);
      chk($sformatf("tbl%0d_valid", i), s_v, tbl[i].ov);
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_data", i), s_d, tbl[i].od);
        chk($sformatf("tbl%0d_strb", i), s_s, tbl[i].os);
        chk($sformatf("tbl%0d_last", i), s_l, tbl[i].ol);
      end
    end

    // Back-pressure: eight results against a stalled consumer.
    for (int j = 0; j < 8; j++) begin
      cyc(1, 32'h1000 + j, 0, 0);
      chk($sformatf("bp_en%0d", j), s_en, j != 7);
    end
    repeat (3) begin
      cyc(1, 32'h1007, 0, 0);
      chk("bp_hold_en", s_en, 0);
      chk("bp_hold_valid", s_v, 1);
      chk("bp_hold_data", s_d,
        128'h00001003_00001002_00001001_00001000);
    end
    cyc(1, 32'h1007, 0, 1);
    chk("bp_rel_en", s_en, 1);
    chk("bp_word1", s_d, 128'h00001003_00001002_00001001_00001000);
    cyc(0, 0, 0, 1);
    chk("bp_w2_valid", s_v, 1);
    chk("bp_word2", s_d, 128'h00001007_00001006_00001005_00001004);
    chk("bp_w2_strb", s_s, 4'hF);
    cyc(0, 0, 0, 1);
    chk("bp_drained", s_v, 0);

    // Flush with nothing buffered emits nothing.
    cyc(0, 0, 1, 1);
    for (int j = 0; j < 10; j++) begin
      cyc(0, 0, 0, 1);
      chk("fe_valid", s_v, 0);
    end

    // Flush coinciding with the last-lane accept.
    cyc(1, 32'hA0, 0, 1);
    cyc(1, 32'hA1, 0, 1);
    cyc(1, 32'hA2, 0, 1);
    cyc(1, 32'hA3, 1, 1);
    cyc(0, 0, 0, 1);
    chk("f4_valid", s_v, 1);
    chk("f4_strb", s_s, 4'hF);
    chk("f4_last", s_l, 1);
    chk("f4_data", s_d, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("f4_no_pend", s_en, 1);
    cyc(0, 0, 0, 1);
    chk("f4_once", s_v, 0);

    // Reset in the middle of a fill discards the partial word.
    cyc(1, 32'hB0, 0, 1);
    cyc(1, 32'hB1, 0, 1);
    cyc(1, 32'hB2, 0, 1);
    cyc(0, 0, 0, 1, 1);
    for (int j = 0; j < 4; j++) begin
      cyc(1, 32'hC0 + j, 0, 1);
      chk("rm_quiet", s_v, 0);
    end
    cyc(0, 0, 0, 1);
    chk("rm_valid", s_v, 1);
    chk("rm_data", s_d, 128'h000000C3_000000C2_000000C1_000000C0);
    chk("rm_strb", s_s, 4'hF);
    chk("rm_last", s_l, 0);

    // Randomized run; a held result stays put until res_en takes it.
    hv = 0; hd = '0; acc_prev = 0; stall_prev = 0;
    p_d = '0; p_sl = '0; n_acc = 0; n_out = 0;
    cyc(0, 0, 0, 1);
    for (int c = 0; c < 10000; c++) begin
      if (!hv || acc_prev) begin
        hv = $urandom_range(0, 3) != 0;
        hd = $urandom;
      end
      hf = $urandom_range(0, 15) == 0;
      hr = $urandom_range(0, 2) != 0;
      cyc(hv, hd, hf, hr);
      if (stall_prev) begin
        chk("hold_data", s_d, p_d);
        chk("hold_ctl", {s_s, s_l}, p_sl);
      end
      acc_prev = hv && s_en;
      if (acc_prev) n_acc++;
      if (s_v && hr) n_out += $countones(s_s);
      stall_prev = s_v && !hr;
      p_d = s_d; p_sl = {s_s, s_l};
    end
    cyc(0, 0, 1, 1);
    if (s_v) n_out += $countones(s_s);
    repeat (6) begin
      cyc(0, 0, 0, 1);
      if (s_v) n_out += $countones(s_s);
    end
    chk("zero_loss", n_out, n_acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
